// File: rtl/video_tpg_timing.sv
// video_tpg_timing: raster timing generator with bar, gradient, checker and solid test patterns.
// All outputs are registered one clock after the counter state they describe.
module video_tpg_timing #(
  parameter int   H_ACTIVE = 640,
  parameter int   H_FP     = 16,
  parameter int   H_SYNC   = 96,
  parameter int   H_BP     = 48,
  parameter int   V_ACTIVE = 480,
  parameter int   V_FP     = 10,
  parameter int   V_SYNC   = 2,
  parameter int   V_BP     = 33,
  parameter logic HS_POL   = 1'b0,
  parameter logic VS_POL   = 1'b0
) (
  input  logic        CLK,
  input  logic        RSTn,
  input  logic        en,
  input  logic [1:0]  pattern_sel,
  input  logic [23:0] solid_rgb,
  output logic [23:0] vdata,
  output logic        hsync,
  output logic        vsync,
  output logic        de,
  output logic        frame_start
);
  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HW      = $clog2(H_TOTAL + 1);
  localparam int VW      = $clog2(V_TOTAL + 1);
  localparam int BAR_W   = H_ACTIVE / 8;
  localparam int BW      = $clog2(BAR_W + 1);
  localparam logic [HW-1:0] H_LAST = HW'(H_TOTAL - 1);
  localparam logic [HW-1:0] H_ACT  = HW'(H_ACTIVE);
  localparam logic [HW-1:0] HS_BEG = HW'(H_ACTIVE + H_FP);
  localparam logic [HW-1:0] HS_END = HW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [VW-1:0] V_LAST = VW'(V_TOTAL - 1);
  localparam logic [VW-1:0] V_ACT  = VW'(V_ACTIVE);
  localparam logic [VW-1:0] VS_BEG = VW'(V_ACTIVE + V_FP);
  localparam logic [VW-1:0] VS_END = VW'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [BW-1:0] B_LAST = BW'(BAR_W - 1);
  // Element 0 is the leftmost bar.
  localparam logic [7:0][23:0] BARS = {24'h000000, 24'h0000FF, 24'hFF0000, 24'hFF00FF,
                                       24'h00FF00, 24'h00FFFF, 24'hFFFF00, 24'hFFFFFF};

  logic [HW-1:0] r_h;
  logic [VW-1:0] r_v;
  logic [7:0]    r_frame;
  logic [1:0]    r_pat;
  logic [2:0]    r_bidx;
  logic [BW-1:0] r_bsub;
  logic          w_h_wrap, w_v_wrap, w_origin, w_active, w_hs, w_vs, w_chk, w_bar_end;
  logic [1:0]    w_pat;
  logic [7:0]    w_h8;
  logic [23:0]   w_pix;

  always_comb begin
    w_h_wrap  = r_h == H_LAST;
    w_v_wrap  = w_h_wrap && (r_v == V_LAST);
    w_origin  = (r_h == '0) && (r_v == '0);
    w_active  = (r_h < H_ACT) && (r_v < V_ACT);
    w_hs      = (r_h >= HS_BEG) && (r_h < HS_END);
    w_vs      = (r_v >= VS_BEG) && (r_v < VS_END);
    w_bar_end = r_bsub == B_LAST;
    w_h8      = 8'(r_h);
    w_chk     = (|((w_h8 + r_frame) & 8'h20)) ^ (|(r_v & VW'(32)));
    // The select takes effect on the very pixel where it is latched.
    w_pat     = w_origin ? pattern_sel : r_pat;
    w_pix     = (w_pat == 2'd0) ? BARS[r_bidx] :
                (w_pat == 2'd1) ? {w_h8, w_h8, w_h8} :
                (w_pat == 2'd2) ? {24{w_chk}} : solid_rgb;
  end

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      r_h         <= '0;
      r_v         <= '0;
      r_frame     <= '0;
      r_pat       <= '0;
      r_bidx      <= '0;
      r_bsub      <= '0;
      vdata       <= '0;
      de          <= 1'b0;
      frame_start <= 1'b0;
      hsync       <= ~HS_POL;
      vsync       <= ~VS_POL;
    end else if (!en) begin
      r_h         <= '0;
      r_v         <= '0;
      r_bidx      <= '0;
      r_bsub      <= '0;
      vdata       <= '0;
      de          <= 1'b0;
      frame_start <= 1'b0;
      hsync       <= ~HS_POL;
      vsync       <= ~VS_POL;
    end else begin
      r_h <= w_h_wrap ? '0 : r_h + HW'(1);
      if (w_h_wrap) r_v <= w_v_wrap ? '0 : r_v + VW'(1);
      if (w_v_wrap) r_frame <= r_frame + 8'd1;
      if (w_origin) r_pat <= pattern_sel;
      // Bar position tracks h_cnt with a sub-counter; the last bar saturates.
      r_bsub <= (w_h_wrap || w_bar_end) ? '0 : r_bsub + BW'(1);
      if (w_h_wrap) r_bidx <= '0;
      else if (w_bar_end && r_bidx != 3'd7) r_bidx <= r_bidx + 3'd1;
      vdata       <= w_active ? w_pix : '0;
      de          <= w_active;
      frame_start <= w_origin;
      hsync       <= w_hs ? HS_POL : ~HS_POL;
      vsync       <= w_vs ? VS_POL : ~VS_POL;
    end
  end
endmodule

// File: tb/tb_video_tpg_timing.sv
// tb_video_tpg_timing: spot-check vector table plus a cycle-by-cycle reference-model scoreboard.
// Uses a reduced raster (100x77) so several frames fit in a short run.
module tb_video_tpg_timing;
  localparam int HA = 84, HFP = 4, HSW = 8, HBP = 4;
  localparam int VA = 70, VFP = 2, VSW = 2, VBP = 3;
  localparam int HT = HA + HFP + HSW + HBP;
  localparam int VT = VA + VFP + VSW + VBP;
  localparam int FT = HT * VT;
  localparam int BARW = HA / 8;
  localparam logic HS_POL = 1'b0;
  localparam logic VS_POL = 1'b1;

  logic        CLK = 1'b0;
  logic        RSTn = 1'b0;
  logic        en = 1'b0;
  logic [1:0]  pattern_sel = 2'd0;
  logic [23:0] solid_rgb = 24'h0;
  logic [23:0] vdata;
  logic        hsync, vsync, de, frame_start;

  video_tpg_timing #(
    .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HSW), .H_BP(HBP),
    .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VSW), .V_BP(VBP),
    .HS_POL(HS_POL), .VS_POL(VS_POL)
  ) dut (
    .CLK(CLK), .RSTn(RSTn), .en(en), .pattern_sel(pattern_sel), .solid_rgb(solid_rgb),
    .vdata(vdata), .hsync(hsync), .vsync(vsync), .de(de), .frame_start(frame_start)
  );

  always #5 CLK = ~CLK;

  int errors = 0;
  int checks = 0;
  int pos = 0;
  logic [27:0] q[$];
  logic [23:0] bars [8] = '{24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
                            24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000};

  typedef struct {
    logic [1:0]  pat;
    logic [23:0] solid;
    int          f, h, v;
    logic [23:0] vd;
    logic        de, hs, vs, fs;
  } vec_t;
  vec_t tv[$];

  task automatic chk(input string nm, input logic [27:0] act, input logic [27:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got vdata/de/hs/vs/fs=%h required %h", nm, act, exp);
    end
  endtask

  function automatic logic [27:0] outs();
    return {vdata, de, hsync, vsync, frame_start};
  endfunction

  // Reference model: expected outputs pushed at each clock edge, popped half a cycle later.
  int mh = 0, mv = 0, mf = 0, bi;
  logic [1:0] mp = 2'd0, p;
  logic act, org;
  logic [7:0] g;
  logic [23:0] pix;
  initial forever begin
    @(posedge CLK or negedge RSTn);
    if (!RSTn) begin
      mh = 0; mv = 0; mf = 0; mp = 2'd0;
      q.delete();
    end else if (!en) begin
      q.push_back({24'h0, 1'b0, ~HS_POL, ~VS_POL, 1'b0});
      mh = 0; mv = 0;
    end else begin
      org = (mh == 0) && (mv == 0);
      p = org ? pattern_sel : mp;
      if (org) mp = pattern_sel;
      act = (mh < HA) && (mv < VA);
      bi = mh / BARW;
      if (bi > 7) bi = 7;
      g = 8'(mh);
      pix = (p == 2'd0) ? bars[bi] :
            (p == 2'd1) ? {g, g, g} :
            (p == 2'd2) ? (((((mh + mf) >> 5) & 1) != ((mv >> 5) & 1)) ? 24'hFFFFFF : 24'h0) :
            solid_rgb;
      q.push_back({act ? pix : 24'h0, act,
                   (mh >= HA + HFP && mh < HA + HFP + HSW) ? HS_POL : ~HS_POL,
                   (mv >= VA + VFP && mv < VA + VFP + VSW) ? VS_POL : ~VS_POL, org});
      mh++;
      if (mh == HT) begin
        mh = 0; mv++;
        if (mv == VT) begin mv = 0; mf = (mf + 1) % 256; end
      end
    end
  end

  initial forever begin
    @(negedge CLK);
    if (RSTn && q.size() > 0) chk("scoreboard", outs(), q.pop_front());
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit expired");
    $fatal(1, "timeout");
  end

  // Reset lands between clock edges; outputs are checked before any edge follows.
  task automatic restart(input logic [1:0] ps, input logic [23:0] s);
    @(negedge CLK);
    #2;
    RSTn = 1'b0; en = 1'b0; pattern_sel = ps; solid_rgb = s;
    #1;
    chk("async_reset", outs(), {24'h0, 1'b0, ~HS_POL, ~VS_POL, 1'b0});
    @(negedge CLK);
    #2;
    RSTn = 1'b1; en = 1'b1;
    pos = 0;
  endtask

  // Advance until the output for counter state (f,h,v) is visible, sampled at a falling edge.
  task automatic goto(input int f, input int h, input int v);
    int t;
    t = f * FT + v * HT + h;
    if (t + 1 > pos) begin
      repeat (t + 1 - pos) @(posedge CLK);
      @(negedge CLK);
      pos = t + 1;
    end
  endtask

  initial begin
    int cur;
    //              pat   solid       f  h   v   vdata        de    hs    vs    fs
    tv.push_back('{2'd0, 24'h0,      0, 0,  0,  24'hFFFFFF, 1'b1, 1'b1, 1'b0, 1'b1});
    tv.push_back('{2'd0, 24'h0,      0, 9,  0,  24'hFFFFFF, 1'b1, 1'b1, 1'b0, 1'b0});
    tv.push_back('{2'd0, 24'h0,      0, 10, 0,  24'hFFFF00, 1'b1, 1'b1, 1'b0, 1'b0});
    tv.push_back('{2'd0, 24'h0,      0, 25, 0,  24'h00FFFF, 1'b1, 1'b1, 1'b0, 1'b0});
    tv.push_back('{2'd0, 24'h0,      0, 65, 0,  24'h0000FF, 1'b1, 1'b1, 1'b0, 1'b0});
    tv.push_back('{2'd0, 24'h0,      0, 83, 0,  24'h000000, 1'b1, 1'b1, 1'b0, 1'b0});
    tv.push_back('{2'd0, 24'h0,      0, 84, 0,  24'h000000, 1'b0, 1'b1, 1'b0, 1'b0});
    tv.push_back('{2'd0, 24'h0,      0, 88, 0,  24'h000000, 1'b0, 1'b0, 1'b0, 1'b0});
    tv.push_back('{2'd0, 24'h0,      0, 95, 0,  24'h000000, 1'b0, 1'b0, 1'b0, 1'b0});
    tv.push_back('{2'd0, 24'h0,      0, 96, 0,  24'h000000, 1'b0, 1'b1, 1'b0, 1'b0});
    tv.push_back('{2'd0, 24'h0,      0, 20, 1,  24'h00FFFF, 1'b1, 1'b1, 1'b0, 1'b0});
    tv.push_back('{2'd0, 24'h0,      0, 0,  69, 24'hFFFFFF, 1'b1, 1'b1, 1'b0, 1'b0});
    tv.push_back('{2'd0, 24'h0,      0, 0,  70, 24'h000000, 1'b0, 1'b1, 1'b0, 1'b0});
    tv.push_back('{2'd0, 24'h0,      0, 50, 72, 24'h000000, 1'b0, 1'b1, 1'b1, 1'b0});
    tv.push_back('{2'd0, 24'h0,      0, 99, 73, 24'h000000, 1'b0, 1'b1, 1'b1, 1'b0});
    tv.push_back('{2'd0, 24'h0,      0, 0,  74, 24'h000000, 1'b0, 1'b1, 1'b0, 1'b0});
    tv.push_back('{2'd0, 24'h0,      1, 0,  0,  24'hFFFFFF, 1'b1, 1'b1, 1'b0, 1'b1});
    tv.push_back('{2'd1, 24'h0,      0, 83, 1,  24'h535353, 1'b1, 1'b1, 1'b0, 1'b0});
    tv.push_back('{2'd1, 24'h0,      0, 37, 5,  24'h252525, 1'b1, 1'b1, 1'b0, 1'b0});
    tv.push_back('{2'd2, 24'h0,      0, 0,  0,  24'h000000, 1'b1, 1'b1, 1'b0, 1'b1});
    tv.push_back('{2'd2, 24'h0,      0, 31, 0,  24'h000000, 1'b1, 1'b1, 1'b0, 1'b0});
    tv.push_back('{2'd2, 24'h0,      0, 32, 0,  24'hFFFFFF, 1'b1, 1'b1, 1'b0, 1'b0});
    tv.push_back('{2'd2, 24'h0,      0, 64, 0,  24'h000000, 1'b1, 1'b1, 1'b0, 1'b0});
    tv.push_back('{2'd2, 24'h0,      0, 0,  32, 24'hFFFFFF, 1'b1, 1'b1, 1'b0, 1'b0});
    tv.push_back('{2'd2, 24'h0,      0, 32, 32, 24'h000000, 1'b1, 1'b1, 1'b0, 1'b0});
    tv.push_back('{2'd2, 24'h0,      1, 0,  0,  24'h000000, 1'b1, 1'b1, 1'b0, 1'b1});
    tv.push_back('{2'd2, 24'h0,      1, 31, 0,  24'hFFFFFF, 1'b1, 1'b1, 1'b0, 1'b0});
    tv.push_back('{2'd3, 24'h123456, 0, 5,  3,  24'h123456, 1'b1, 1'b1, 1'b0, 1'b0});
    tv.push_back('{2'd3, 24'h123456, 0, 90, 3,  24'h000000, 1'b0, 1'b0, 1'b0, 1'b0});

    cur = -1;
    foreach (tv[i]) begin
      if (int'(tv[i].pat) != cur || tv[i].f * FT + tv[i].v * HT + tv[i].h + 1 <= pos) begin
        restart(tv[i].pat, tv[i].solid);
        cur = int'(tv[i].pat);
      end
      goto(tv[i].f, tv[i].h, tv[i].v);
      chk($sformatf("vec%0d(p%0d f%0d h%0d v%0d)", i, tv[i].pat, tv[i].f, tv[i].h, tv[i].v),
          outs(), {tv[i].vd, tv[i].de, tv[i].hs, tv[i].vs, tv[i].fs});
    end

    // Select change mid-frame only takes effect at the next frame.
    restart(2'd0, 24'h123456);
    goto(0, 0, 40);
    pattern_sel = 2'd3;
    goto(0, 10, 41);
    chk("latch_hold", outs(), {24'hFFFF00, 1'b1, 1'b1, 1'b0, 1'b0});
    goto(1, 0, 0);
    chk("latch_frame1_start", outs(), {24'h123456, 1'b1, 1'b1, 1'b0, 1'b1});
    goto(1, 10, 41);
    chk("latch_next", outs(), {24'h123456, 1'b1, 1'b1, 1'b0, 1'b0});

    // Enable dropped mid-line: idle outputs, then a fresh frame from (0,0).
    restart(2'd1, 24'h0);
    goto(0, 50, 1);
    chk("en_before", outs(), {24'h323232, 1'b1, 1'b1, 1'b0, 1'b0});
    en = 1'b0;
    @(posedge CLK);
    @(negedge CLK);
    chk("en_idle", outs(), {24'h0, 1'b0, ~HS_POL, ~VS_POL, 1'b0});
    pattern_sel = 2'd3;
    solid_rgb = 24'hABCDEF;
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    chk("en_idle_hold", outs(), {24'h0, 1'b0, ~HS_POL, ~VS_POL, 1'b0});
    en = 1'b1;
    @(posedge CLK);
    @(negedge CLK);
    chk("en_restart_fs", outs(), {24'hABCDEF, 1'b1, 1'b1, 1'b0, 1'b1});
    @(posedge CLK);
    @(negedge CLK);
    chk("en_fs_once", outs(), {24'hABCDEF, 1'b1, 1'b1, 1'b0, 1'b0});
    restart(2'd0, 24'h0);

    @(negedge CLK);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/video_tpg_timing.md
VIDEO_TPG_TIMING -- requirements
Module: video_tpg_timing

Interface
REQ-001 The block SHALL have these parameters (name, default, meaning):
- H_ACTIVE, 640, active pixels per line
- H_FP, 16, horizontal front porch
- H_SYNC, 96, horizontal sync width
- H_BP, 48, horizontal back porch
- V_ACTIVE, 480, active lines per frame
- V_FP, 10, vertical front porch
- V_SYNC, 2, vertical sync width
- V_BP, 33, vertical back porch
- HS_POL, 0, asserted hsync level
- VS_POL, 0, asserted vsync level

REQ-002 The block SHALL have these ports (name, direction, width, meaning):
- CLK, in, 1, pixel clock; single clock domain
- RSTn, in, 1, asynchronous active-low reset
- en, in, 1, run enable
- pattern_sel, in, 2, pattern select
- solid_rgb, in, 24, solid colour {R,G,B}
- vdata, out, 24, pixel {R[23:16],G[15:8],B[7:0]}
- hsync, out, 1, horizontal sync
- vsync, out, 1, vertical sync
- de, out, 1, data enable (active video)
- frame_start, out, 1, one-cycle pulse on first active pixel of frame

REQ-003 The clock SHALL be named CLK and the reset SHALL be named RSTn. RSTn is asynchronous and active-low, and no other clock exists in the block.

Function
REQ-004 Counters:
- h_cnt counts 0..H_TOTAL-1, where H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP (800 at defaults).
- v_cnt counts 0..V_TOTAL-1, where V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP (525 at defaults).
- v_cnt advances when h_cnt wraps from H_TOTAL-1 to 0.
- v_cnt wraps from V_TOTAL-1 to 0 on the same cycle h_cnt wraps.

REQ-005 While en=0:
- counters SHALL be held at h_cnt=0, v_cnt=0;
- de, frame_start and vdata SHALL be 0;
- hsync and vsync SHALL be at their deasserted levels.
When en rises, counting SHALL start from (0,0) on the next clock.

REQ-006 Timing decodes:
- active = (h_cnt < H_ACTIVE) and (v_cnt < V_ACTIVE).
- hsync is asserted for h_cnt in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC).
- vsync is asserted for v_cnt in [V_ACTIVE+V_FP, V_ACTIVE+V_FP+V_SYNC) for whole lines.
- The asserted level of hsync is HS_POL and of vsync is VS_POL.

REQ-007 All outputs SHALL be registered and mutually aligned. Outputs at cycle n reflect the counter state of cycle n-1, so the fixed latency is 1 clock.

REQ-008 vdata SHALL be 24'h000000 whenever de=0.

REQ-009 pattern_sel SHALL be sampled only on the cycle counters equal (0,0). The sampled value governs the whole frame, and mid-frame changes have no effect until the next frame.

REQ-010 Pattern 0 is colour bars: 8 vertical bars, each BAR_W = H_ACTIVE/8 pixels wide.
- Left to right: FFFFFF, FFFF00, 00FFFF, 00FF00, FF00FF, FF0000, 0000FF, 000000.
- The bar index SHALL come from a sub-counter reset at h_cnt=0, not from a divider.
- Pixels beyond 8*BAR_W SHALL show the last bar.

REQ-011 Pattern 1 is a gradient: R=G=B=h_cnt[7:0], which wraps every 256 pixels.

REQ-012 Pattern 2 is a moving checkerboard.
- A pixel is white if ((h_cnt + frame_cnt)[5] XOR v_cnt[5]) = 1; otherwise it is black.
- frame_cnt is an 8-bit counter that increments at each v_cnt wrap and wraps 255 -> 0.

REQ-013 Pattern 3 is a solid colour: vdata = solid_rgb, sampled every active cycle.

REQ-014 frame_start SHALL be 1 for exactly the output cycle whose counter state was (0,0) with en=1; otherwise it is 0.

Reset
REQ-015 While RSTn=0, the following SHALL be cleared immediately, independent of CLK:
- h_cnt=0, v_cnt=0, frame_cnt=0;
- latched pattern=0;
- vdata=0, de=0, frame_start=0;
- hsync=~HS_POL, vsync=~VS_POL.

REQ-016 After RSTn deasserts, the first counter advance SHALL occur on the first CLK edge with en=1.

REQ-017 A reset asserted mid-frame SHALL abort the frame. The next frame SHALL begin at (0,0) with frame_start.

Verification
REQ-018 Default timing, en=1 held for 2 frames:
- de high for 640 consecutive cycles per line on 480 lines;
- hsync low for 96 cycles starting 656 cycles after de rises;
- line period 800 cycles; frame period 420000 cycles;
- vsync low for 2 lines, i.e. 1600 cycles.

REQ-019 pattern_sel=0:
- pixel 0 = FFFFFF; pixel 79 = FFFFFF; pixel 80 = FFFF00; pixel 639 = 000000;
- vdata = 0 during blanking.

REQ-020 Select latching:
- pattern_sel changes 0->3 at line 100, with solid_rgb=123456;
- bars continue to the end of the frame;
- the next frame shows 123456 on every active pixel.

REQ-021 Pattern 2 over frames 0 and 1:
- frame 0: pixel (0,0) black and pixel (32,0) white;
- frame 1: pixel (31,0) white because the offset is 1.

REQ-022 Enable and reset:
- en deasserted mid-line then reasserted: outputs idle during en=0, then frame_start appears 1 cycle after the first counting cycle.
- RSTn pulsed low mid-frame between CLK edges: outputs return to their reset values without a clock edge.
